arrow_rom_arbiter: RTL

ARROW_ROM_ARBITER -- requirements
Module: arrow_rom_arbiter

---
 rtl/arrow_rom_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/arrow_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous arrow-sprite ROM between two renderers.
// Each grant carries a requester tag through the ROM latency so the returned word is routed back to its port.
module arrow_rom_arbiter #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_vld,
    output logic [DATA_W-1:0] p1_data,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    output logic              p2_gnt,
    output logic              p2_vld,
    output logic [DATA_W-1:0] p2_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              clr_stats,
    output logic [15:0]       conflict_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TAG_D = ROM_LATENCY;

    typedef enum logic {
        LAST_P1 = 1'b0,
        LAST_P2 = 1'b1
    } last_e;

    typedef struct packed {
        logic vld;
        logic is_p2;
    } tag_t;

    last_e             r_last;
    last_e             w_last_nxt;
    logic              w_p1_win;
    logic              w_p1_gnt;
    logic              w_p2_gnt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [ADDR_W-1:0] w_rom_addr;
    tag_t              r_tag [TAG_D];
    tag_t              w_tag_out;
    logic              r_p1_vld;
    logic              r_p2_vld;
    logic [DATA_W-1:0] r_p1_data;
    logic [DATA_W-1:0] r_p2_data;
    logic [CNT_W-1:0]  r_cnt;

    // Player 1 wins when alone, or on a tie when player 2 was granted last.
    assign w_p1_win = p1_req && (!p2_req || (r_last == LAST_P2));

    always_comb begin
        w_p1_gnt   = 1'b0;
        w_p2_gnt   = 1'b0;
        w_rom_addr = r_addr_hold;
        w_last_nxt = r_last;
        if (!reset) begin
            if (w_p1_win) begin
                w_p1_gnt   = 1'b1;
                w_rom_addr = p1_addr;
                w_last_nxt = LAST_P1;
            end else if (p2_req) begin
                w_p2_gnt   = 1'b1;
                w_rom_addr = p2_addr;
                w_last_nxt = LAST_P2;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last      <= LAST_P2;
            r_addr_hold <= '0;
        end else begin
            r_last      <= w_last_nxt;
            r_addr_hold <= w_rom_addr;
        end
    end

    // Tag pipeline aligned with the ROM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(TAG_D); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: (w_p1_gnt || w_p2_gnt), is_p2: w_p2_gnt};
            for (int i = 1; i < int'(TAG_D); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tag_out = r_tag[TAG_D-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_p1_vld  <= 1'b0;
            r_p2_vld  <= 1'b0;
            r_p1_data <= '0;
            r_p2_data <= '0;
        end else begin
            r_p1_vld <= w_tag_out.vld && !w_tag_out.is_p2;
            r_p2_vld <= w_tag_out.vld && w_tag_out.is_p2;
            if (w_tag_out.vld && !w_tag_out.is_p2) begin
                r_p1_data <= rom_q;
            end
            if (w_tag_out.vld && w_tag_out.is_p2) begin
                r_p2_data <= rom_q;
            end
        end
    end

    // Saturating tie counter; clear wins over increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr_stats) begin
            r_cnt <= '0;
        end else if (p1_req && p2_req && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign p1_gnt       = w_p1_gnt;
    assign p2_gnt       = w_p2_gnt;
    assign rom_addr     = w_rom_addr;
    assign p1_vld       = r_p1_vld;
    assign p2_vld       = r_p2_vld;
    assign p1_data      = r_p1_data;
    assign p2_data      = r_p2_data;
    assign conflict_cnt = r_cnt;

endmodule
